parallel_serializer: RTL and testbench
======================================

// Module: parallel_serializer
// PURPOSE
//   Parallel-to-serial front end placed directly upstream of the 4-bit serial shift register.
//   Accepts a WIDTH-bit word over a valid/ready handshake and emits one bit per CLK on Serial_out.
//   Serial_out wires straight to the shift register's serial input.
//   The shift register shifts on every edge, so Serial_out idles at 0 between frames (its reset value).
// PARAMETERS
//   WIDTH      4  data bits per frame (2..16)
//   MSB_FIRST  1  1: Data_in[WIDTH-1] transmitted first; 0: Data_in[0] first
// PORTS
//   CLK          in   1      single clock, all state on rising edge
//   Reset_n      in   1      asynchronous, active-low reset
//   Data_in      in   WIDTH  parallel word, sampled only on handshake
//   Data_valid   in   1      upstream has a word on Data_in
//   Data_ready   out  1      block accepts Data_in at this edge if Data_valid=1
//   Serial_out   out  1      registered serial bit to shift register input
//   Frame_start  out  1      high during the cycle Serial_out carries a frame's first bit
//   Busy         out  1      high while a frame (data or parity) is on Serial_out
// BEHAVIOUR
//   - Reset (Reset_n=0, async): state IDLE, bit counter 0, shadow reg 0, Serial_out=0,
//     Frame_start=0, Busy=0, Data_ready forced 0 while Reset_n low.
//   - States: IDLE, SHIFT, PARITY (PARITY exists only with SERIALIZER_PARITY_EN).
//   - Handshake: transfer when Data_valid & Data_ready at a rising edge. Data_ready is combinational:
//     1 in IDLE, and 1 in the final bit cycle of a frame (last SHIFT bit, or PARITY if enabled).
//     0 otherwise. Data_valid with Data_ready=0: no capture; upstream holds word and valid.
//   - IDLE: Serial_out=0. On transfer: load shadow, counter=0, go SHIFT.
//     First data bit appears on Serial_out in the cycle after the accept edge (latency 1 clock).
//   - SHIFT: Serial_out = current bit of shadow; each edge advances one bit, counter++.
//     Edge with counter==WIDTH-1: parity enabled -> PARITY;
//     else transfer at this edge -> reload, stay SHIFT (no gap bit); else -> IDLE.
//   - PARITY: Serial_out = even parity (XOR) of the captured word.
//     Next edge: transfer -> reload, SHIFT; else IDLE.
//   - Frame_start=1 exactly during bit 0 of every frame, back-to-back frames included. Busy = state!=IDLE.
//   - Frame length: WIDTH clocks (WIDTH+1 with parity). Max throughput: one word per frame length.
//   - Data_in changes without a handshake never affect the frame in flight (shadow reg isolates it).
//   - Reset mid-frame: frame aborted immediately, outputs to reset values; no partial-frame resume.
//   - All outputs registered except Data_ready.
// CONFIGURATION
//   SERIALIZER_PARITY_EN defined: PARITY state compiled in.
//     One even-parity bit is appended after each word; frame = WIDTH+1 clocks.
//   SERIALIZER_PARITY_EN undefined: no PARITY state, no parity logic; frame = WIDTH clocks.
// TESTING (WIDTH=4, MSB_FIRST=1 unless stated)
//   1. Reset release, Data_valid=0 for 10 clk -> Serial_out=0, Busy=0, Data_ready=1, Frame_start never high.
//   2. Accept 4'b1011 -> Serial_out 1,0,1,1 on next 4 cycles, then 0.
//      After 4 more edges the shift register's parallel outputs read 1011, MSB first (Bit_3=1).
//   3. Data_valid held with 4'hA, then 4'h5 -> serial 1010 0101 with no gap.
//      Data_ready high only in idle and in cycles 4 and 8. Frame_start in cycles 1 and 5.
//   4. Reset_n low after 2 bits of 4'hF -> Serial_out, Busy, Data_ready drop to 0 without waiting for an edge.
//      After release, a new 4'h6 frame emits 0,1,1,0.
//   5. MSB_FIRST=0, accept 4'b1011 -> Serial_out 1,1,0,1.
//   6. SERIALIZER_PARITY_EN, accept 4'b1011 -> 1,0,1,1 then parity 1.
//      Data_ready high only in the parity cycle. Busy for 5 cycles.

Source files
------------

// File: rtl/parallel_serializer.sv
// -----------------------------------------------------------------------------
// parallel_serializer
//   Parallel-to-serial front end for a downstream serial shift register.
//   Takes a WIDTH-bit word over a valid/ready handshake and emits one bit per
//   CLK on Serial_out. Serial_out idles at 0 between frames because the
//   downstream register shifts on every edge.
//
//   Build option: define SERIALIZER_PARITY_EN to append one even-parity bit
//   after each word (frame = WIDTH+1 clocks). With the macro undefined there
//   is no parity state and no parity logic (frame = WIDTH clocks).
//
// Parameters
//   WIDTH       data bits per frame (2..16)
//   MSB_FIRST   1: Data_in[WIDTH-1] sent first, 0: Data_in[0] sent first
//
// Ports
//   CLK          in   rising-edge clock
//   Reset_n      in   asynchronous active-low reset
//   Data_in      in   parallel word, sampled only on a handshake
//   Data_valid   in   upstream has a word on Data_in
//   Data_ready   out  combinational; word accepted at this edge if Data_valid
//   Serial_out   out  registered serial bit
//   Frame_start  out  registered; high while Serial_out carries bit 0
//   Busy         out  registered; high while a frame is on Serial_out
//
// State table
//   state  | meaning
//   IDLE   | no frame, Serial_out held at 0, ready for a word
//   SHIFT  | data bit bit_cnt of shadow on Serial_out
//   PARITY | even parity of shadow on Serial_out (parity build only)
// -----------------------------------------------------------------------------
module parallel_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Data_valid,
  output logic             Data_ready,
  output logic             Serial_out,
  output logic             Frame_start,
  output logic             Busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
`endif

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shadow;
  logic             last_bit;
  logic             xfer;

  // Bit k of the frame in transmit order.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
    if (MSB_FIRST)
      return w[LAST - k];
    else
      return w[k];
  endfunction

  // Final bit cycle of a frame: a new word may be taken here so the next
  // frame follows without a gap bit.
`ifdef SERIALIZER_PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (bit_cnt == LAST);
`endif

  assign Data_ready = Reset_n && ((state == IDLE) || last_bit);
  assign xfer       = Data_valid && Data_ready;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shadow      <= '0;
      Serial_out  <= 1'b0;
      Frame_start <= 1'b0;
      Busy        <= 1'b0;
    end else if (xfer) begin
      // Handshake only happens in IDLE or the last bit cycle, so a capture
      // always starts a fresh frame.
      state       <= SHIFT;
      bit_cnt     <= '0;
      shadow      <= Data_in;
      Serial_out  <= pick(Data_in, '0);
      Frame_start <= 1'b1;
      Busy        <= 1'b1;
    end else begin
      Frame_start <= 1'b0;
      case (state)
        IDLE: begin
          Serial_out <= 1'b0;
          Busy       <= 1'b0;
        end
        SHIFT: begin
          if (bit_cnt != LAST) begin
            bit_cnt    <= bit_cnt + CW'(1);
            Serial_out <= pick(shadow, bit_cnt + CW'(1));
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state      <= PARITY;
            Serial_out <= ^shadow;
`else
            state      <= IDLE;
            bit_cnt    <= '0;
            Serial_out <= 1'b0;
            Busy       <= 1'b0;
`endif
          end
        end
        default: begin
          state      <= IDLE;
          bit_cnt    <= '0;
          Serial_out <= 1'b0;
          Busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_serializer.sv
module tb_parallel_serializer;

  localparam int WIDTH = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             CLK     = 1'b0;
  logic             Reset_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data2   = '0;
  logic             valid   = 1'b0;
  logic             valid2  = 1'b0;
  logic ready, serial, fs, busy;
  logic ready2, serial2, fs2, busy2;

  always #5 CLK = ~CLK;

  parallel_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .Data_in     (data_in),
    .Data_valid  (valid),
    .Data_ready  (ready),
    .Serial_out  (serial),
    .Frame_start (fs),
    .Busy        (busy)
  );

  parallel_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .Data_in     (data2),
    .Data_valid  (valid2),
    .Data_ready  (ready2),
    .Serial_out  (serial2),
    .Frame_start (fs2),
    .Busy        (busy2)
  );

  // Downstream 4-bit shift register fed by the MSB-first instance.
  logic [3:0] sr_dut;
  always @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) sr_dut <= 4'h0;
    else          sr_dut <= {sr_dut[2:0], serial};
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: queue of {frame_start, bit} for the current and future
  // cycles; front entry is what Serial_out carries now.
  logic [1:0] q[$];
  logic [1:0] q2[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input bit second, input logic [WIDTH-1:0] w, input bit msb);
    for (int k = 0; k < FLEN; k++) begin
      logic b;
      if (k == WIDTH) b = ^w;
      else            b = msb ? w[WIDTH-1-k] : w[k];
      if (second) q2.push_back({k == 0, b});
      else        q.push_back({k == 0, b});
    end
  endfunction

  // Called at edge+1 with inputs already driven; returns at next edge+1.
  task automatic step(output bit acc1);
    bit acc2;
    #2;
    check("data_ready", ready, 16'(q.size() <= 1));
    check("data_ready_lsb", ready2, 16'(q2.size() <= 1));
    acc1 = valid && (q.size() <= 1);
    acc2 = valid2 && (q2.size() <= 1);
    @(posedge CLK);
    if (q.size() > 0)  void'(q.pop_front());
    if (q2.size() > 0) void'(q2.pop_front());
    if (acc1) push_frame(1'b0, data_in, 1'b1);
    if (acc2) push_frame(1'b1, data2, 1'b0);
    #1;
    check("serial_out",  serial, (q.size() > 0) ? 16'(q[0][0]) : 16'h0);
    check("frame_start", fs,     (q.size() > 0) ? 16'(q[0][1]) : 16'h0);
    check("busy",        busy,   16'(q.size() > 0));
    check("serial_out_lsb",  serial2, (q2.size() > 0) ? 16'(q2[0][0]) : 16'h0);
    check("frame_start_lsb", fs2,     (q2.size() > 0) ? 16'(q2[0][1]) : 16'h0);
    check("busy_lsb",        busy2,   16'(q2.size() > 0));
  endtask

  initial begin
    bit         a;
    logic [3:0] got;
    logic [9:0] stream;

    // Reset state
    #3;
    check("rst_serial", serial, 16'h0);
    check("rst_busy",   busy,   16'h0);
    check("rst_fs",     fs,     16'h0);
    check("rst_ready",  ready,  16'h0);
    #10;
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) step(a);

    // Single word 1011
    data_in = 4'b1011;
    valid   = 1'b1;
    step(a);
    got   = {3'b000, serial};
    valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      data_in = 4'($urandom);
      step(a);
      got = {got[2:0], serial};
    end
    check("t2_bits", got, 16'hB);
    step(a);
    check("t2_shift_reg", sr_dut, 16'hB);
    for (int i = 0; i < FLEN; i++) step(a);

    // Back-to-back: A then 5 with valid held
    data_in = 4'hA;
    valid   = 1'b1;
    step(a);
    stream  = {9'd0, serial};
    data_in = 4'h5;
    for (int i = 1; i < 2 * FLEN; i++) begin
      step(a);
      if (a) valid = 1'b0;
      stream = {stream[8:0], serial};
    end
`ifdef SERIALIZER_PARITY_EN
    check("t3_stream", stream, 16'({4'hA, 1'b0, 4'h5, 1'b0}));
`else
    check("t3_stream", stream, 16'({2'b00, 8'hA5}));
`endif
    valid = 1'b0;
    for (int i = 0; i < FLEN + 1; i++) step(a);

    // Reset mid-frame
    data_in = 4'hF;
    valid   = 1'b1;
    step(a);
    valid = 1'b0;
    step(a);
    #3;
    Reset_n = 1'b0;
    q.delete();
    q2.delete();
    #1;
    check("t4_serial", serial, 16'h0);
    check("t4_busy",   busy,   16'h0);
    check("t4_ready",  ready,  16'h0);
    check("t4_fs",     fs,     16'h0);
    @(posedge CLK);
    #3;
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;
    data_in = 4'h6;
    valid   = 1'b1;
    step(a);
    got   = {3'b000, serial};
    valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step(a);
      got = {got[2:0], serial};
    end
    check("t4_bits", got, 16'h6);
    for (int i = 0; i < FLEN; i++) step(a);

    // LSB-first instance: 1011 -> 1,1,0,1
    data2  = 4'b1011;
    valid2 = 1'b1;
    step(a);
    got    = {3'b000, serial2};
    valid2 = 1'b0;
    for (int i = 1; i < 4; i++) begin
      data2 = 4'($urandom);
      step(a);
      got = {got[2:0], serial2};
    end
    check("t5_bits", got, 16'hD);
    for (int i = 0; i < FLEN; i++) step(a);

`ifdef SERIALIZER_PARITY_EN
    // Parity frame: 1011 then parity 1
    data_in = 4'b1011;
    valid   = 1'b1;
    step(a);
    stream  = {9'd0, serial};
    valid   = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step(a);
      stream = {stream[8:0], serial};
    end
    check("t6_parity_frame", stream, 16'h17);
    for (int i = 0; i < FLEN; i++) step(a);
`endif

    // Randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      valid   = ($urandom_range(0, 9) < 6);
      valid2  = ($urandom_range(0, 9) < 5);
      data_in = 4'($urandom);
      data2   = 4'($urandom);
      step(a);
    end
    valid  = 1'b0;
    valid2 = 1'b0;
    for (int i = 0; i < FLEN + 1; i++) step(a);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
